// File: rtl/grf_operand_fetch_pkg.sv
// Shared definitions for the Decode-stage GRF operand fetch block.
// Holds register-file geometry, the D/E payload layout and small helpers
// used by the bypass and hazard logic.
package grf_operand_fetch_pkg;

  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam int         OPND_W   = 32;
  localparam int         REG_NUM  = 32;

  // Payload carried across the D/E boundary alongside op_valid.
  typedef struct packed {
    logic [OPND_W-1:0] rs_val;
    logic [OPND_W-1:0] rt_val;
    logic [4:0]        dst;
    logic [31:0]       pc;
  } de_payload_t;

  // True when this cycle's writeback targets register r.
  function automatic logic wb_targets(input logic       wb_en,
                                      input logic [4:0] wb_addr,
                                      input logic [4:0] r);
    return wb_en && (wb_addr == r);
  endfunction

  // Resolved operand: same-cycle writeback wins over the GRF read,
  // and $0 always reads zero (a writeback to $0 is never forwarded).
  function automatic logic [OPND_W-1:0] fwd_operand(input logic              wb_en,
                                                    input logic [4:0]        wb_addr,
                                                    input logic [OPND_W-1:0] wb_data,
                                                    input logic [4:0]        r,
                                                    input logic [OPND_W-1:0] grf_rd);
    logic [OPND_W-1:0] val;
    if (r == REG_ZERO) begin
      val = '0;
    end else if (wb_targets(wb_en, wb_addr, r)) begin
      val = wb_data;
    end else begin
      val = grf_rd;
    end
    return val;
  endfunction

endpackage

// File: rtl/grf_scoreboard.sv
// Pending-write scoreboard: one busy bit per GRF register, $0 never busy.
// Ports: clk/reset/flush control; wb_en/wb_addr clear a bit; set_en/set_addr
// mark a newly issued destination; busy_vec exposes the full vector.
module grf_scoreboard
  import grf_operand_fetch_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic               wb_en,
  input  logic [4:0]         wb_addr,
  input  logic               set_en,
  input  logic [4:0]         set_addr,
  output logic [REG_NUM-1:0] busy_vec
);

  logic [REG_NUM-1:0] busy_q;
  logic [REG_NUM-1:0] busy_d;

  // Clear first, then set, so a same-register clear/set leaves the bit set:
  // the writeback retires the old producer while the new one takes over.
  always_comb begin
    busy_d = busy_q;
    if (wb_en && (wb_addr != REG_ZERO)) begin
      busy_d[wb_addr] = 1'b0;
    end
    if (set_en && (set_addr != REG_ZERO)) begin
      busy_d[set_addr] = 1'b1;
    end
    busy_d[REG_ZERO] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy_vec = busy_q;

endmodule

// File: rtl/grf_operand_fetch.sv
// Decode-stage operand fetch: scoreboard-based issue stall, writeback bypass
// to both read ports, D/E operand register and a stall-watchdog deadlock flag.
// Ports: iss_* describe the issuing instruction, grf_rd1/2 are the GRF reads
// addressed by iss_rs/iss_rt, wb_* mirror the GRF write port, op_* are the
// registered D/E outputs, stall is combinational, deadlock is sticky.
module grf_operand_fetch
  import grf_operand_fetch_pkg::*;
#(
  parameter int STALL_MAX = 16,
  parameter int CNT_W     = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              iss_valid,
  input  logic [4:0]        iss_rs,
  input  logic [4:0]        iss_rt,
  input  logic              iss_use_rs,
  input  logic              iss_use_rt,
  input  logic              iss_wr,
  input  logic [4:0]        iss_dst,
  input  logic [31:0]       iss_pc,
  input  logic [OPND_W-1:0] grf_rd1,
  input  logic [OPND_W-1:0] grf_rd2,
  input  logic              wb_en,
  input  logic [4:0]        wb_addr,
  input  logic [OPND_W-1:0] wb_data,
  input  logic              flush,
  output logic              stall,
  output logic              op_valid,
  output logic [OPND_W-1:0] op_rs_val,
  output logic [OPND_W-1:0] op_rt_val,
  output logic [4:0]        op_dst,
  output logic [31:0]       op_pc,
  output logic              deadlock
);

  logic [REG_NUM-1:0] busy_vec;
  logic [OPND_W-1:0]  rs_fwd;
  logic [OPND_W-1:0]  rt_fwd;
  logic               hit_rs;
  logic               hit_rt;
  logic               hit_dst;
  logic               fire;
  logic               sb_set;

  de_payload_t        de_q;
  de_payload_t        de_d;
  logic               op_valid_q;
  logic               op_valid_d;

  logic [CNT_W-1:0]   stall_cnt_q;
  logic [CNT_W-1:0]   stall_cnt_d;
  logic               deadlock_q;
  logic               deadlock_d;

  // ---------------------------------------------------------------------
  // Bypass and hazard detection
  // ---------------------------------------------------------------------
  assign rs_fwd = fwd_operand(wb_en, wb_addr, wb_data, iss_rs, grf_rd1);
  assign rt_fwd = fwd_operand(wb_en, wb_addr, wb_data, iss_rt, grf_rd2);

  // A busy register being written back this very cycle is no longer a hazard:
  // sources pick the value up through the bypass, and a destination's old
  // producer retires before the new one claims the bit.
  assign hit_rs  = iss_use_rs && busy_vec[iss_rs]
                   && !wb_targets(wb_en, wb_addr, iss_rs);
  assign hit_rt  = iss_use_rt && busy_vec[iss_rt]
                   && !wb_targets(wb_en, wb_addr, iss_rt);
  assign hit_dst = iss_wr && (iss_dst != REG_ZERO) && busy_vec[iss_dst]
                   && !wb_targets(wb_en, wb_addr, iss_dst);

  assign stall  = iss_valid && !flush && (hit_rs || hit_rt || hit_dst);
  assign fire   = iss_valid && !stall && !flush;
  assign sb_set = fire && iss_wr && (iss_dst != REG_ZERO);

  grf_scoreboard u_sb (
    .clk      (clk),
    .reset    (reset),
    .flush    (flush),
    .wb_en    (wb_en),
    .wb_addr  (wb_addr),
    .set_en   (sb_set),
    .set_addr (iss_dst),
    .busy_vec (busy_vec)
  );

  // ---------------------------------------------------------------------
  // D/E boundary register: payload holds on bubbles so E sees stable data
  // ---------------------------------------------------------------------
  always_comb begin
    de_d       = de_q;
    op_valid_d = 1'b0;
    if (fire) begin
      op_valid_d  = 1'b1;
      de_d.rs_val = rs_fwd;
      de_d.rt_val = rt_fwd;
      de_d.dst    = iss_wr ? iss_dst : REG_ZERO;
      de_d.pc     = iss_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      op_valid_q <= 1'b0;
      de_q       <= '0;
    end else begin
      op_valid_q <= op_valid_d;
      de_q       <= de_d;
    end
  end

  assign op_valid  = op_valid_q;
  assign op_rs_val = de_q.rs_val;
  assign op_rt_val = de_q.rt_val;
  assign op_dst    = de_q.dst;
  assign op_pc     = de_q.pc;

  // ---------------------------------------------------------------------
  // Stall watchdog: counts consecutive stall cycles, saturating
  // ---------------------------------------------------------------------
  always_comb begin
    stall_cnt_d = '0;
    if (stall) begin
      stall_cnt_d = (stall_cnt_q == {CNT_W{1'b1}}) ? stall_cnt_q
                                                    : stall_cnt_q + CNT_W'(1);
    end
    // Flag rises on the same edge the count reaches the limit.
    deadlock_d = deadlock_q || (stall_cnt_d >= CNT_W'(STALL_MAX));
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      stall_cnt_q <= '0;
      deadlock_q  <= 1'b0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      deadlock_q  <= deadlock_d;
    end
  end

  assign deadlock = deadlock_q;

endmodule

// File: tb/tb_grf_operand_fetch.sv
module tb_grf_operand_fetch;

  localparam int STALL_MAX = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        iss_valid;
  logic [4:0]  iss_rs, iss_rt, iss_dst;
  logic        iss_use_rs, iss_use_rt, iss_wr;
  logic [31:0] iss_pc, grf_rd1, grf_rd2;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        flush;
  logic        stall, op_valid, deadlock;
  logic [31:0] op_rs_val, op_rt_val, op_pc;
  logic [4:0]  op_dst;

  always #5 clk = ~clk;

  grf_operand_fetch #(.STALL_MAX(STALL_MAX), .CNT_W(5)) u_dut (
    .clk(clk), .reset(reset), .iss_valid(iss_valid), .iss_rs(iss_rs),
    .iss_rt(iss_rt), .iss_use_rs(iss_use_rs), .iss_use_rt(iss_use_rt),
    .iss_wr(iss_wr), .iss_dst(iss_dst), .iss_pc(iss_pc), .grf_rd1(grf_rd1),
    .grf_rd2(grf_rd2), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .flush(flush), .stall(stall), .op_valid(op_valid), .op_rs_val(op_rs_val),
    .op_rt_val(op_rt_val), .op_dst(op_dst), .op_pc(op_pc), .deadlock(deadlock)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: set of registers with a write in flight, plus the
  // expected D/E contents and a run-length of consecutive stalled cycles.
  bit          m_busy [32];
  int          m_streak;
  bit          m_dead;
  logic        m_valid;
  logic [31:0] m_rs, m_rt, m_pc;
  logic [4:0]  m_dst;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit m_pending(input bit use_it, input logic [4:0] r);
    bit wb_now;
    wb_now = wb_en && (wb_addr == r);
    return use_it && (r != 0) && m_busy[r] && !wb_now;
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] r, input logic [31:0] rd);
    if (r == 0) return 32'h0;
    if (wb_en && wb_addr == r) return wb_data;
    return rd;
  endfunction

  function automatic logic [31:0] m_busy_word();
    logic [31:0] w;
    for (int i = 0; i < 32; i++) w[i] = m_busy[i];
    return w;
  endfunction

  task automatic idle();
    reset = 0; flush = 0; iss_valid = 0; iss_rs = 0; iss_rt = 0;
    iss_use_rs = 0; iss_use_rt = 0; iss_wr = 0; iss_dst = 0; iss_pc = 0;
    grf_rd1 = 0; grf_rd2 = 0; wb_en = 0; wb_addr = 0; wb_data = 0;
  endtask

  task automatic issue(input logic [4:0] rs, input bit urs, input logic [4:0] rt,
                       input bit urt, input bit wr, input logic [4:0] dst,
                       input logic [31:0] pc);
    iss_valid = 1; iss_rs = rs; iss_use_rs = urs; iss_rt = rt; iss_use_rt = urt;
    iss_wr = wr; iss_dst = dst; iss_pc = pc;
  endtask

  // One clock: check combinational stall, advance model, check registers.
  task automatic step(input string tag);
    bit          exp_stall, fire;
    logic [31:0] frs, frt;
    #1;
    exp_stall = iss_valid && !flush &&
                (m_pending(iss_use_rs, iss_rs) || m_pending(iss_use_rt, iss_rt) ||
                 m_pending(iss_wr, iss_dst));
    chk({tag, "_stall"}, {31'b0, stall}, {31'b0, exp_stall});
    fire = iss_valid && !exp_stall && !flush;
    frs  = m_read(iss_rs, grf_rd1);
    frt  = m_read(iss_rt, grf_rd2);
    if (reset || flush) begin
      foreach (m_busy[i]) m_busy[i] = 0;
      m_valid = 0; m_rs = 0; m_rt = 0; m_dst = 0; m_pc = 0;
      m_streak = 0; m_dead = 0;
    end else begin
      if (wb_en && wb_addr != 0) m_busy[wb_addr] = 0;
      if (fire && iss_wr && iss_dst != 0) m_busy[iss_dst] = 1;
      m_valid = fire;
      if (fire) begin
        m_rs = frs; m_rt = frt; m_dst = iss_wr ? iss_dst : 5'd0; m_pc = iss_pc;
      end
      m_streak = exp_stall ? ((m_streak < 31) ? m_streak + 1 : 31) : 0;
      if (m_streak >= STALL_MAX) m_dead = 1;
    end
    @(posedge clk); #1;
    chk({tag, "_valid"}, {31'b0, op_valid}, {31'b0, m_valid});
    chk({tag, "_rs"},    op_rs_val, m_rs);
    chk({tag, "_rt"},    op_rt_val, m_rt);
    chk({tag, "_dst"},   {27'b0, op_dst}, {27'b0, m_dst});
    chk({tag, "_pc"},    op_pc, m_pc);
    chk({tag, "_dead"},  {31'b0, deadlock}, {31'b0, m_dead});
    chk({tag, "_busy"},  u_dut.busy_vec, m_busy_word());
  endtask

  initial begin
    foreach (m_busy[i]) m_busy[i] = 0;
    m_streak = 0; m_dead = 0; m_valid = 0;
    m_rs = 0; m_rt = 0; m_dst = 0; m_pc = 0;
    idle();

    // Reset state
    reset = 1; step("rst"); reset = 0;
    chk("rst_opvalid", {31'b0, op_valid}, 32'd0);
    chk("rst_dead", {31'b0, deadlock}, 32'd0);

    // Plain issue, no hazard
    issue(5'd3, 1, 5'd4, 1, 0, 5'd0, 32'h100); grf_rd1 = 32'h11; grf_rd2 = 32'h22;
    step("plain");
    chk("plain_rs", op_rs_val, 32'h11);
    chk("plain_rt", op_rt_val, 32'h22);
    chk("plain_v", {31'b0, op_valid}, 32'd1);

    // RAW on $5, resolved by bypassed writeback
    idle(); issue(5'd1, 0, 5'd2, 0, 1, 5'd5, 32'h104); step("wr5");
    idle(); issue(5'd5, 1, 5'd0, 0, 0, 5'd0, 32'h108); grf_rd1 = 32'h1;
    for (int i = 0; i < 3; i++) step("raw5");
    chk("raw5_bubble", {31'b0, op_valid}, 32'd0);
    wb_en = 1; wb_addr = 5'd5; wb_data = 32'hABCD; step("raw5_wb");
    chk("raw5_fwd", op_rs_val, 32'hABCD);

    // Same-cycle clear and set of $7: set wins
    idle(); issue(5'd0, 0, 5'd0, 0, 1, 5'd7, 32'h10C); step("wr7a");
    idle(); issue(5'd0, 0, 5'd0, 0, 1, 5'd7, 32'h110);
    wb_en = 1; wb_addr = 5'd7; wb_data = 32'h7; step("wr7b");
    chk("busy7_kept", {31'b0, u_dut.busy_vec[7]}, 32'd1);
    idle(); issue(5'd7, 1, 5'd0, 0, 0, 5'd0, 32'h114); step("rd7_stall");
    wb_en = 1; wb_addr = 5'd7; wb_data = 32'h77; step("rd7_wb");
    chk("rd7_fwd", op_rs_val, 32'h77);

    // $0 handling
    idle(); issue(5'd0, 0, 5'd0, 0, 1, 5'd0, 32'h118); step("wr0");
    chk("wr0_dst", {27'b0, op_dst}, 32'd0);
    idle(); issue(5'd0, 1, 5'd0, 1, 0, 5'd0, 32'h11C); grf_rd1 = 32'hFFFF;
    wb_en = 1; wb_addr = 5'd0; wb_data = 32'h55; step("rd0");
    chk("rd0_val", op_rs_val, 32'h0);
    chk("rd0_rt", op_rt_val, 32'h0);

    // Deadlock watchdog on $9, then flush
    idle(); issue(5'd0, 0, 5'd0, 0, 1, 5'd9, 32'h120); step("wr9");
    idle(); issue(5'd9, 1, 5'd9, 1, 0, 5'd0, 32'h124);
    for (int i = 1; i <= STALL_MAX; i++) begin
      step("dl");
      if (i == STALL_MAX - 1) chk("dl_early", {31'b0, deadlock}, 32'd0);
    end
    chk("dl_set", {31'b0, deadlock}, 32'd1);
    flush = 1; step("dl_flush"); flush = 0;
    chk("dl_clr", {31'b0, deadlock}, 32'd0);
    chk("dl_busy", u_dut.busy_vec, 32'd0);
    step("dl_after");

    // Reset in the middle of a stall on $2
    idle(); issue(5'd0, 0, 5'd0, 0, 1, 5'd2, 32'h130); step("wr2");
    idle(); issue(5'd2, 1, 5'd0, 0, 0, 5'd0, 32'h134); step("rd2_stall");
    reset = 1; step("rst_mid"); reset = 0;
    chk("rstmid_v", {31'b0, op_valid}, 32'd0);
    chk("rstmid_pc", op_pc, 32'd0);
    step("rd2_after");

    // Randomized traffic over a small register window to provoke hazards
    for (int n = 0; n < 600; n++) begin
      idle();
      iss_valid  = ($urandom_range(0, 9) < 8);
      iss_rs     = 5'($urandom_range(0, 7));
      iss_rt     = 5'($urandom_range(0, 7));
      iss_dst    = 5'($urandom_range(0, 7));
      iss_use_rs = 1'($urandom_range(0, 1));
      iss_use_rt = 1'($urandom_range(0, 1));
      iss_wr     = 1'($urandom_range(0, 1));
      iss_pc     = $urandom;
      grf_rd1    = $urandom;
      grf_rd2    = $urandom;
      wb_en      = ($urandom_range(0, 9) < 4);
      wb_addr    = 5'($urandom_range(0, 7));
      wb_data    = $urandom;
      flush      = ($urandom_range(0, 99) < 2);
      reset      = ($urandom_range(0, 199) < 1);
      step("rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
